// File: rtl/key_pkg.sv
// Shared constants and state encoding for the key assembly / streaming path.
package key_pkg;
  localparam int KEY_WIDTH  = 512;
  localparam int WORD_WIDTH = 32;
  localparam int NUM_WORDS  = KEY_WIDTH / WORD_WIDTH;
  localparam int IDX_W      = $clog2(NUM_WORDS);

  // Streamer FSM states, kept as plain constants so older tools can consume them
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_STREAM = 2'd1;
  localparam state_t S_DONE   = 2'd2;
endpackage

// File: rtl/key_word_streamer_if.sv
// Load / word-stream bus of key_word_streamer. slave = streamer, master = producer/consumer side.
interface key_word_streamer_if;
  import key_pkg::*;
  logic [KEY_WIDTH-1:0]  iKey;
  logic                  iLoad;
  logic                  iReady;
  logic [WORD_WIDTH-1:0] oWord;
  logic                  oValid;
  logic [IDX_W-1:0]      oWord_index;
  logic                  oBusy;
  logic                  oDone;

  modport slave  (input iKey, iLoad, iReady, output oWord, oValid, oWord_index, oBusy, oDone);
  modport master (output iKey, iLoad, iReady, input oWord, oValid, oWord_index, oBusy, oDone);
endinterface

// File: rtl/key_word_streamer.sv
// Streams a loaded 512-bit key out as 32-bit words (word 0 = key[31:0]) over valid/ready.
// Optional macro KEY_STREAM_REPEAT_EN: wrap after word 15 into an endless keystream and
// accept reloads mid-stream; DONE is then never entered.
module key_word_streamer
  import key_pkg::*;
(
  input logic                iClk,
  input logic                iRst,
  key_word_streamer_if.slave bus
);

  state_t                state_q, state_d;
  logic [KEY_WIDTH-1:0]  key_q,   key_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic                  valid_q, valid_d;
  logic                  done_q,  done_d;

  logic ld_ok, xfer, last;

`ifdef KEY_STREAM_REPEAT_EN
  assign ld_ok = bus.iLoad;
`else
  assign ld_ok = bus.iLoad && (state_q != S_STREAM);
`endif
  assign xfer = valid_q && bus.iReady;
  assign last = (idx_q == IDX_W'(NUM_WORDS - 1));

  // Next-state: load wins over transfer; a transfer rotates the key so the next word sits low
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    done_d  = done_q;
    if (ld_ok) begin
      state_d = S_STREAM;
      key_d   = bus.iKey;
      idx_d   = '0;
      valid_d = 1'b1;
      done_d  = 1'b0;
    end else if (xfer) begin
      // Rotate, not shift: after a full pass the register holds the original key again
      key_d = {key_q[WORD_WIDTH-1:0], key_q[KEY_WIDTH-1:WORD_WIDTH]};
      idx_d = idx_q + 1'b1;
`ifndef KEY_STREAM_REPEAT_EN
      if (last) begin
        state_d = S_DONE;
        idx_d   = idx_q;
        valid_d = 1'b0;
        done_d  = 1'b1;
      end
`endif
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge iClk) begin
    if (!iRst) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // The current word is always the low slice of the rotator
  assign bus.oWord       = key_q[WORD_WIDTH-1:0];
  assign bus.oValid      = valid_q;
  assign bus.oWord_index = idx_q;
  // STREAM is the only state offering a word, so busy and valid coincide
  assign bus.oBusy       = valid_q;
  assign bus.oDone       = done_q;

  // last is only consulted in the non-repeating build
  logic unused_ok;
  assign unused_ok = last;

endmodule

// File: tb/tb_key_word_streamer.sv
// Directed bench for key_word_streamer with a word-array reference model checked every cycle.
module tb_key_word_streamer;
  import key_pkg::*;

  logic iClk = 1'b0;
  logic iRst;
  always #5 iClk = ~iClk;

  key_word_streamer_if ifc ();
  key_word_streamer dut (.iClk(iClk), .iRst(iRst), .bus(ifc));

`ifdef KEY_STREAM_REPEAT_EN
  localparam bit REPEAT = 1'b1;
`else
  localparam bit REPEAT = 1'b0;
`endif

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference model: key held as an array of words, a position and a phase (0 idle, 1 streaming, 2 done)
  logic [31:0] m_key [NUM_WORDS];
  int m_pos = 0;
  int m_ph  = 0;
  bit m_fresh = 0;
  bit m_known = 0;

  always @(posedge iClk) begin
    if (!iRst) begin
      m_ph = 0; m_pos = 0; m_fresh = 1; m_known = 1;
    end else if (m_known) begin
      if (ifc.iLoad && (m_ph != 1 || REPEAT)) begin
        for (int w = 0; w < NUM_WORDS; w++) m_key[w] = ifc.iKey[w*32 +: 32];
        m_pos = 0; m_ph = 1; m_fresh = 0;
      end else if (m_ph == 1 && ifc.iReady) begin
        m_pos++;
        if (m_pos == NUM_WORDS) begin
          if (REPEAT) m_pos = 0;
          else m_ph = 2;
        end
      end
    end
  end

  // Compare every cycle away from the active edge
  always @(negedge iClk) begin
    if (m_known) begin
      chk("valid", 32'(ifc.oValid), 32'(m_ph == 1));
      chk("busy",  32'(ifc.oBusy),  32'(m_ph == 1));
      chk("done",  32'(ifc.oDone),  32'(m_ph == 2));
      if (m_ph == 1) begin
        chk("word", ifc.oWord, m_key[m_pos]);
        chk("index", 32'(ifc.oWord_index), 32'(m_pos));
      end else if (m_fresh) begin
        chk("rst_word", ifc.oWord, 32'h0);
        chk("rst_index", 32'(ifc.oWord_index), 32'h0);
      end
    end
  end

  function automatic logic [KEY_WIDTH-1:0] mk(input logic [31:0] base);
    logic [KEY_WIDTH-1:0] r;
    for (int i = 0; i < NUM_WORDS; i++) r[i*32 +: 32] = base + 32'(i);
    return r;
  endfunction

  task automatic tick();
    @(posedge iClk);
    #2;
  endtask

  task automatic load(input logic [KEY_WIDTH-1:0] k);
    ifc.iKey = k; ifc.iLoad = 1'b1;
    tick();
    ifc.iLoad = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (!ifc.oDone && n < lim) begin tick(); n++; end
    chk("done_reached", 32'(ifc.oDone), 32'h1);
  endtask

  task automatic wait_idx(input int idx, input int lim);
    int n = 0;
    while (!(ifc.oValid && ifc.oWord_index == IDX_W'(idx)) && n < lim) begin tick(); n++; end
    chk("idx_reached", 32'(ifc.oWord_index), 32'(idx));
  endtask

  initial begin
    iRst = 1'b0; ifc.iLoad = 1'b0; ifc.iReady = 1'b0; ifc.iKey = '0;
    repeat (2) tick();
    chk("lit_rst_valid", 32'(ifc.oValid), 32'h0);
    chk("lit_rst_word",  ifc.oWord, 32'h0);
    chk("lit_rst_done",  32'(ifc.oDone), 32'h0);
    iRst = 1'b1;
    tick();

`ifndef KEY_STREAM_REPEAT_EN
    // Full-rate stream
    ifc.iReady = 1'b1;
    load(mk(32'hA5A5_0000));
    chk("lit_w0", ifc.oWord, 32'hA5A5_0000);
    chk("lit_v0", 32'(ifc.oValid), 32'h1);
    repeat (15) tick();
    chk("lit_w15", ifc.oWord, 32'hA5A5_000F);
    chk("lit_i15", 32'(ifc.oWord_index), 32'hF);
    tick();
    chk("lit_done", 32'(ifc.oDone), 32'h1);
    chk("lit_vdone", 32'(ifc.oValid), 32'h0);

    // Backpressure pattern 1,0,0,1
    ifc.iReady = 1'b0;
    load(mk(32'hA5A5_0000));
    for (int p = 0; p < 80 && !ifc.oDone; p++) begin
      ifc.iReady = (p % 4 == 0) || (p % 4 == 3);
      tick();
    end
    chk("bp_done", 32'(ifc.oDone), 32'h1);

    // Load mid-stream is ignored
    ifc.iReady = 1'b1;
    load(mk(32'h1234_0000));
    wait_idx(6, 20);
    load(mk(32'hC0DE_0000));
    chk("lit_ign_w7", ifc.oWord, 32'h1234_0007);
    wait_done(20);
    load(mk(32'hC0DE_0000));
    chk("lit_new_w0", ifc.oWord, 32'hC0DE_0000);
    wait_done(20);

    // Reset mid-stream
    load(mk(32'h5555_0000));
    wait_idx(8, 20);
    iRst = 1'b0;
    tick();
    iRst = 1'b1;
    chk("lit_mrst_valid", 32'(ifc.oValid), 32'h0);
    chk("lit_mrst_word",  ifc.oWord, 32'h0);
    chk("lit_mrst_idx",   32'(ifc.oWord_index), 32'h0);
    tick();
    load(mk(32'h7777_0000));
    chk("lit_rl_w0", ifc.oWord, 32'h7777_0000);
    wait_done(20);
    tick();
`else
    // Continuous keystream
    ifc.iReady = 1'b1;
    load(mk(32'hA5A5_0000));
    chk("lit_w0", ifc.oWord, 32'hA5A5_0000);
    repeat (16) tick();
    chk("lit_wrap_w", ifc.oWord, 32'hA5A5_0000);
    chk("lit_wrap_i", 32'(ifc.oWord_index), 32'h0);
    repeat (23) tick();
    chk("lit_w7", ifc.oWord, 32'hA5A5_0007);
    chk("lit_nodone", 32'(ifc.oDone), 32'h0);
    // Reload mid-stream restarts at word 0
    load(mk(32'hC0DE_0000));
    chk("lit_rel_w0", ifc.oWord, 32'hC0DE_0000);
    chk("lit_rel_v", 32'(ifc.oValid), 32'h1);
    repeat (5) tick();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/key_word_streamer.md
Name: key_word_streamer

Overview:
- Reverse of the 512-bit key assembly path: loads one full assembled key and streams it out as 32-bit words over a valid/ready handshake.
- Sits between the key register and any consumer that takes the key one word at a time (e.g. per-word XOR stage, key echo/readback).
- Word order matches assembly order: word 0 = key[31:0], word 15 = key[511:480].

Parameters:
- KEY_WIDTH, 512, total key bits; must be an integer multiple of WORD_WIDTH.
- WORD_WIDTH, 32, bits per emitted word.
- NUM_WORDS, KEY_WIDTH/WORD_WIDTH (16), derived; not overridden.

Ports:
- iClk  input  1  clock.
- iRst  input  1  reset: synchronous, active-low; sampled only on the rising edge of iClk.
- iKey  input  KEY_WIDTH  key to stream; sampled only on an accepted load.
- iLoad  input  1  load strobe; accepted only in IDLE or DONE.
- iReady  input  1  consumer ready.
- oWord  output  WORD_WIDTH  current word.
- oValid  output  1  oWord valid.
- oWord_index  output  $clog2(NUM_WORDS)  index of the word on oWord (0..15).
- oBusy  output  1  high in STREAM.
- oDone  output  1  high in DONE.

Behaviour:
- All outputs are registered.
- Reset (iRst=0 at a rising edge): state=IDLE; internal key register=0; oWord=0, oValid=0, oWord_index=0, oBusy=0, oDone=0.
- Reset has priority over everything, including mid-stream; a stream interrupted by reset is abandoned and is not resumed.
- States: IDLE, STREAM, DONE.
- IDLE: oValid=0.
  - iLoad=1 captures iKey into the rotate register and sets index=0.
  - Next state STREAM; oValid=1 and oWord=iKey[31:0] in the cycle after the load (latency 1).
- STREAM:
  - A transfer occurs when oValid && iReady at a rising edge.
  - On transfer: the rotate register rotates right by WORD_WIDTH; oWord = the new low word; index increments by 1.
  - When oValid=1 and iReady=0, oWord and oWord_index hold stable (no drop, no change).
  - Transfer of word NUM_WORDS-1 moves to DONE: oValid=0, oBusy=0, oDone=1.
  - iLoad is ignored in STREAM.
- DONE: oDone stays high until an accepted iLoad; iLoad behaves exactly as in IDLE (oDone clears on the same edge).
- Back-to-back throughput: one word per cycle while iReady=1; 16 words take exactly 16 cycles after oValid first rises.
- Index width: 4 bits; it never wraps in the base build.
- The key register is a rotator rather than a shifter, so after a full stream it holds the original key (needed for the optional feature).
- iLoad and iReady high together in IDLE/DONE: iReady has no effect, since no word is valid yet.

Optional Feature:
- Macro: KEY_STREAM_REPEAT_EN.
- Defined:
  - Transfer of word 15 wraps the index to 0 and stays in STREAM; oWord = key[31:0] again, giving a continuous repeating keystream.
  - DONE is never entered; oDone stays 0.
  - iLoad in STREAM is accepted and restarts at word 0 with the new key; oValid remains 1 throughout.
- Not defined: behaviour exactly as in Behaviour above.

Decomposition:
- Shared package key_pkg: KEY_WIDTH, WORD_WIDTH, NUM_WORDS, index width constant, state enum (IDLE/STREAM/DONE).
- The assembler uses the same package constants.
- No sub-module: rotator, counter and FSM fit in a single module.

Test Plan:
- Reset then load key with word i = 32'hA5A5_0000 + i, iReady=1 constant -> oValid rises 1 cycle after load; words 0..15 appear on consecutive cycles with index 0..15; oDone=1 on the cycle after word 15.
- Same key, iReady toggling 1,0,0,1 ... -> each word appears exactly once in order; oWord/index stable while iReady=0; no word skipped.
- iLoad pulsed with a different key mid-stream (after word 5, base build) -> ignored; original words 6..15 complete; next load in DONE streams the new key from word 0.
- iRst=0 asserted at word 8 -> next edge: all outputs 0, state IDLE; a subsequent load restarts at word 0.
- Round trip: stream a random 512-bit key into the key assembler input -> assembled key equals the original; the assembler's can-encrypt flag asserts.
- KEY_STREAM_REPEAT_EN defined, iReady=1 for 40 cycles -> sequence 0..15,0..15,0..7 of the same key; oDone never asserts.
